// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word width, RAM handshake states and the arbiter FSM encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    IGNT  = 2'b01,
    DGNT  = 2'b10,
    FAULT = 2'b11
  } arb_state_t;

  // Bits needed to hold 0..max_val, never narrower than min_w.
  function automatic int cnt_width(input int max_val, input int min_w);
    int w;
    w = $clog2(max_val + 1);
    return (w < min_w) ? min_w : w;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, with
// starvation guard for instruction requests and a grant-wait watchdog.
//
// state | meaning
// IDLE  | no grant; RAM outputs low; picks the next requester
// IGNT  | instruction read owns the RAM until ACCESS or withdrawal
// DGNT  | data read/write owns the RAM until ACCESS or withdrawal
// FAULT | RAM error or wait timeout; err high, everything quiet until RST
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      ihit,
  output logic      dhit,
  output word_t     iload,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);

  localparam int SW = cnt_width(STARVE_LIMIT, 3);
  localparam int WW = cnt_width(TIMEOUT, 1);

  arb_state_t    r_state;
  arb_state_t    w_state_next;
  logic [SW-1:0] r_dstreak;
  logic [WW-1:0] r_wait;

  logic w_dreq;
  logic w_starve;
  logic w_access;
  logic w_stall;

  assign w_dreq   = dREN | dWEN;
  assign w_starve = (r_dstreak == SW'(STARVE_LIMIT)) && iREN;
  assign w_access = (ramstate == ACCESS);
  // The wait value counts completed grant cycles, so the TIMEOUT-th stalled cycle trips it.
  assign w_stall  = (ramstate == ERROR) || (r_wait == WW'(TIMEOUT - 1));

  always_comb begin
    w_state_next = r_state;
    ihit         = 1'b0;
    dhit         = 1'b0;
    iload        = '0;
    dload        = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    err          = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_dreq && !w_starve) begin
          w_state_next = DGNT;
        end else if (iREN) begin
          w_state_next = IGNT;
        end
      end

      IGNT: begin
        if (!iREN) begin
          w_state_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (w_access) begin
            ihit         = ~RST;
            iload        = RST ? '0 : ramload;
            w_state_next = IDLE;
          end else if (w_stall) begin
            w_state_next = FAULT;
          end
        end
      end

      DGNT: begin
        if (!w_dreq) begin
          w_state_next = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (w_access) begin
            dhit         = ~RST;
            dload        = RST ? '0 : ramload;
            w_state_next = IDLE;
          end else if (w_stall) begin
            w_state_next = FAULT;
          end
        end
      end

      FAULT: begin
        err = 1'b1;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_dstreak <= '0;
      r_wait    <= '0;
    end else begin
      r_state <= w_state_next;

      // Staying in the same grant means another cycle without ACCESS; any other move restarts.
      if ((r_state == IGNT || r_state == DGNT) && (w_state_next == r_state)) begin
        r_wait <= r_wait + WW'(1);
      end else begin
        r_wait <= '0;
      end

      if (ihit) begin
        r_dstreak <= '0;
      end else if (dhit && iREN && (r_dstreak != SW'(STARVE_LIMIT))) begin
        r_dstreak <= r_dstreak + SW'(1);
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive data grants allowed while an instruction request waits.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles a grant may wait for ramstate ACCESS.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset: CLK input 1, clock; RST input 1, synchronous active-high reset.
REQ-004 iREN  input  1  instruction read request.
REQ-005 iaddr  input  32  instruction address (word_t).
REQ-006 dREN, dWEN  input  1 each  data read request and data write request.
REQ-007 daddr, dstore  input  32 each  data address and data write value.
REQ-008 ihit, dhit  output  1 each  one-cycle completion strobes.
REQ-009 iload, dload  output  32 each  read data returned to the requester.
REQ-010 ramREN, ramWEN  output  1 each  RAM read and write strobes.
REQ-011 ramaddr, ramstore  output  32 each  RAM address and RAM write data.
REQ-012 ramload  input  32  RAM read data.
REQ-013 ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS or ERROR.
REQ-014 err  output  1  sticky fault flag.

Function
REQ-015 FSM states SHALL be IDLE, IGNT, DGNT and FAULT.
REQ-016 IDLE, choosing the next grant:
- If (dREN|dWEN) and starvation is not active, go to DGNT.
- Otherwise, if iREN, go to IGNT.
- Otherwise stay in IDLE.
REQ-017 Starvation SHALL be active when dstreak==STARVE_LIMIT and iREN=1; data then waits for exactly one instruction grant.
REQ-018 dstreak (3 bits min, saturating at STARVE_LIMIT):
- increments on each dhit while iREN=1;
- clears on each ihit.
REQ-019 In IGNT: ramREN=1, ramWEN=0, ramaddr=iaddr.
REQ-020 In DGNT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. A write takes precedence over a read.
REQ-021 While in a grant state, the grant SHALL NOT switch requesters, regardless of new requests.
REQ-022 When ramstate==ACCESS in IGNT: ihit=1 and iload=ramload combinationally in that cycle; the next state is IDLE.
REQ-023 When ramstate==ACCESS in DGNT: dhit=1 and dload=ramload in that cycle; the next state is IDLE.
REQ-024 Minimum turnaround SHALL be 1 idle cycle between grants. Back-to-back access of the same requester therefore costs latency+1 cycles.
REQ-025 iload/dload SHALL be 0 whenever the corresponding hit is 0.
REQ-026 Request withdrawal: if the granted request drops before ACCESS, return to IDLE next cycle with no hit and strobes low.
REQ-027 A wait counter SHALL clear on entering a grant state and increment each grant cycle without ACCESS.
REQ-028 If the wait counter reaches TIMEOUT, or ramstate==ERROR in a grant state, go to FAULT.
REQ-029 In FAULT: err=1, all strobes 0, no hits; FAULT is left only by RST.
REQ-030 When IDLE and no request is pending, all RAM outputs SHALL be 0.
REQ-031 ihit and dhit SHALL never both be 1 in the same cycle.

Reset
REQ-032 On a CLK edge with RST=1: state=IDLE, dstreak=0, wait counter=0, err=0.
REQ-033 Consequences of reset:
- All outputs are 0 in the following cycle.
- Reset mid-access abandons the access with no hit.
- RST has priority over every transition, including FAULT.

Structure
REQ-034 ramstate_t and word_t SHALL come from cpu_types_pkg.
REQ-035 arb_state_t (IDLE/IGNT/DGNT/FAULT) SHALL be added to cpu_types_pkg.
REQ-036 No sub-module SHALL be used: one sequential process for state/counters plus combinational output and next-state logic.

Verification
REQ-037 Simultaneous requests: iREN=1 and dREN=1 with daddr=0x40, RAM latency 2 -> DGNT first, dhit in cycle 3 with dload=ramload, then IGNT.
REQ-038 Starvation:
- Stimulus: dREN held high with iREN=1, STARVE_LIMIT=4.
- Response: exactly 4 dhits, then 1 ihit, then data resumes.
REQ-039 Write precedence: dWEN=dREN=1, daddr=0x80, dstore=0xECE43700 -> ramWEN=1, ramREN=0, ramstore=0xECE43700, dhit on ACCESS.
REQ-040 Timeout: ramstate held BUSY for 255 grant cycles -> FAULT, err=1, strobes 0; RST=1 for one edge -> IDLE, err=0.
REQ-041 Withdrawal and reset mid-access:
- iREN dropped during BUSY -> IDLE next cycle, no ihit.
- RST during DGNT -> no dhit, all outputs 0 next cycle.
